// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
//   EX-stage ALU control decoder plus a HI/LO multiply/divide unit.
//   - alu_ctrl decodes alu_op/funct into a 4-bit ALU operation code.
//   - MULTU runs an unsigned shift-add multiplier, one bit per cycle.
//   - DIVU runs an unsigned restoring divider, one bit per cycle.
//   - MFHI/MFLO read HI/LO on hilo_rd; MTHI/MTLO write them.
//   - HI/LO instructions stall while the unit is busy; other ops proceed.
//
// Parameters:
//   WIDTH     datapath width, any even value 8..64 (default 32)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   valid_in  EX-stage instruction valid
//   alu_op    main-control ALU opcode class
//   funct     R-type function field
//   rs_val    first operand
//   rt_val    second operand
//   alu_ctrl  ALU operation code (combinational)
//   hilo_rd   HI or LO read data for MFHI/MFLO (combinational)
//   hi, lo    architectural HI/LO registers
//   stall     freeze upstream pipeline (combinational)
//   md_done   one-cycle pulse after multiply/divide results land
//
// Configuration macro:
//   ALU_EXEC_DIV_EN  when defined, the divider and DIV state are built;
//                    otherwise DIVU is a no-op.
// -----------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             md_done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef ALU_EXEC_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

  state_t state_r;
  state_t state_nxt_s;

  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_nxt_s;
  logic                 iter_last_s;

  logic rtype_s;
  logic op_multu_s;
  logic op_mfhi_s;
  logic op_mflo_s;
  logic op_mthi_s;
  logic op_mtlo_s;
  logic hilo_op_s;

`ifdef ALU_EXEC_DIV_EN
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic             op_divu_s;
`endif

  // Instruction class decode for the HI/LO group.
  always_comb begin
    rtype_s    = valid_in && (alu_op == 2'b10);
    op_multu_s = rtype_s && (funct == F_MULTU);
    op_mfhi_s  = rtype_s && (funct == F_MFHI);
    op_mflo_s  = rtype_s && (funct == F_MFLO);
    op_mthi_s  = rtype_s && (funct == F_MTHI);
    op_mtlo_s  = rtype_s && (funct == F_MTLO);
`ifdef ALU_EXEC_DIV_EN
    op_divu_s  = rtype_s && (funct == F_DIVU);
    hilo_op_s  = op_multu_s | op_divu_s | op_mfhi_s | op_mflo_s | op_mthi_s | op_mtlo_s;
`else
    // DIVU is a no-op in this build, so it never needs to wait for the unit.
    hilo_op_s  = op_multu_s | op_mfhi_s | op_mflo_s | op_mthi_s | op_mtlo_s;
`endif
  end

  // ALU operation code from alu_op and funct.
  always_comb begin
    alu_ctrl = 4'b0010;
    case (alu_op)
      2'b00: alu_ctrl = 4'b0010;
      2'b01: alu_ctrl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: alu_ctrl = 4'b0010;
          6'b100010, 6'b100011: alu_ctrl = 4'b0110;
          6'b100100:            alu_ctrl = 4'b0000;
          6'b100101:            alu_ctrl = 4'b0001;
          6'b100110:            alu_ctrl = 4'b0011;
          6'b100111:            alu_ctrl = 4'b1100;
          6'b101010:            alu_ctrl = 4'b0111;
          6'b101011:            alu_ctrl = 4'b1011;
          6'b000000:            alu_ctrl = 4'b1000;
          6'b000010:            alu_ctrl = 4'b1001;
          6'b000011:            alu_ctrl = 4'b1010;
          default:              alu_ctrl = 4'b0010;
        endcase
      end
      2'b11:   alu_ctrl = 4'b0010;
      default: alu_ctrl = 4'b0010;
    endcase
  end

  // MFHI/MFLO read port; reads whatever HI/LO currently hold.
  always_comb begin
    hilo_rd = {WIDTH{1'b0}};
    if (op_mfhi_s) begin
      hilo_rd = hi;
    end else if (op_mflo_s) begin
      hilo_rd = lo;
    end else begin
      hilo_rd = {WIDTH{1'b0}};
    end
  end

  // One multiply step: add multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole product right by one.
  always_comb begin
    mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
              + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    mul_nxt_s = {mul_sum_s, prod_r[WIDTH-1:1]};
  end

`ifdef ALU_EXEC_DIV_EN
  // One restoring divide step. A zero divisor always "fits", which yields
  // an all-ones quotient and the dividend as remainder without special casing.
  always_comb begin
    div_shift_s = {rem_r, quo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, dvs_r};
    if (!div_diff_s[WIDTH]) begin
      rem_nxt_s = div_diff_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_s = div_shift_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Next-state and stall logic.
  always_comb begin
    state_nxt_s = state_r;
    stall       = 1'b0;
    iter_last_s = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        stall = 1'b0;
        if (op_multu_s) begin
          state_nxt_s = MUL;
`ifdef ALU_EXEC_DIV_EN
        end else if (op_divu_s) begin
          state_nxt_s = DIV;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        stall = hilo_op_s;
        if (iter_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MUL;
        end
      end
`ifdef ALU_EXEC_DIV_EN
      DIV: begin
        stall = hilo_op_s;
        if (iter_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DIV;
        end
      end
`endif
      default: begin
        stall       = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latching, iteration, HI/LO writes and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      md_done <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
`ifdef ALU_EXEC_DIV_EN
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
`endif
    end else begin
      md_done <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (op_multu_s) begin
            prod_r  <= {{WIDTH{1'b0}}, rt_val};
            mcand_r <= rs_val;
`ifdef ALU_EXEC_DIV_EN
          end else if (op_divu_s) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= rs_val;
            dvs_r <= rt_val;
`endif
          end else if (op_mthi_s) begin
            hi <= rs_val;
          end else if (op_mtlo_s) begin
            lo <= rs_val;
          end
        end
        MUL: begin
          prod_r <= mul_nxt_s;
          if (iter_last_s) begin
            hi      <= mul_nxt_s[2*WIDTH-1:WIDTH];
            lo      <= mul_nxt_s[WIDTH-1:0];
            md_done <= 1'b1;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef ALU_EXEC_DIV_EN
        DIV: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          if (iter_last_s) begin
            hi      <= rem_nxt_s;
            lo      <= quo_nxt_s;
            md_done <= 1'b1;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`endif
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//   Self-checking bench for alu_exec_ctrl (WIDTH=32). A transaction-level
//   model (64-bit products, native / and %, a remaining-cycle count) predicts
//   every output each cycle; directed scenarios add literal expectations.
//   Honours ALU_EXEC_DIV_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_exec_ctrl;

  localparam int W = 32;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         valid_in = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   funct = 6'b000000;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] hilo_rd;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         stall;
  logic         md_done;

  alu_exec_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .alu_op   (alu_op),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_ctrl (alu_ctrl),
    .hilo_rd  (hilo_rd),
    .hi       (hi),
    .lo       (lo),
    .stall    (stall),
    .md_done  (md_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  bit           m_busy = 1'b0, m_done = 1'b0;
  int           m_left = 0;

  function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return 4'b0110;
    if (op != 2'b10) return 4'b0010;
    case (f)
      6'b100000, 6'b100001: return 4'b0010;
      6'b100010, 6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b0011;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b101011: return 4'b1011;
      6'b000000: return 4'b1000;
      6'b000010: return 4'b1001;
      6'b000011: return 4'b1010;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit is_hilo(input logic [5:0] f);
    if (f == F_MULTU || f == F_MFHI || f == F_MFLO || f == F_MTHI || f == F_MTLO) return 1'b1;
`ifdef ALU_EXEC_DIV_EN
    if (f == F_DIVU) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_rhi; m_lo = m_rlo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (valid_in && alu_op == 2'b10) begin
        case (funct)
          F_MULTU: begin
            {m_rhi, m_rlo} = {32'd0, rs_val} * {32'd0, rt_val};
            m_busy = 1'b1; m_left = W;
          end
`ifdef ALU_EXEC_DIV_EN
          F_DIVU: begin
            if (rt_val == '0) begin
              m_rlo = '1; m_rhi = rs_val;
            end else begin
              m_rlo = rs_val / rt_val; m_rhi = rs_val % rt_val;
            end
            m_busy = 1'b1; m_left = W;
          end
`endif
          F_MTHI: m_hi = rs_val;
          F_MTLO: m_lo = rs_val;
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic         e_sel;
  logic         e_stall;
  logic [W-1:0] e_rd;

  always @(negedge clk) begin
    if (chk_en) begin
      e_sel   = valid_in && (alu_op == 2'b10);
      e_stall = m_busy && e_sel && is_hilo(funct);
      e_rd    = (e_sel && funct == F_MFHI) ? m_hi : ((e_sel && funct == F_MFLO) ? m_lo : '0);
      chk("alu_ctrl", {60'd0, alu_ctrl}, {60'd0, exp_ctrl(alu_op, funct)});
      chk("stall",    {63'd0, stall},    {63'd0, e_stall});
      chk("hilo_rd",  {32'd0, hilo_rd},  {32'd0, e_rd});
      chk("hi",       {32'd0, hi},       {32'd0, m_hi});
      chk("lo",       {32'd0, lo},       {32'd0, m_lo});
      chk("md_done",  {63'd0, md_done},  {63'd0, m_done});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    valid_in = v; alu_op = op; funct = f; rs_val = a; rt_val = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply/divide and wait (bounded) for md_done; lat=0 on timeout.
  task automatic run_md(input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat);
    drive(1'b1, 2'b10, f, a, b);
    tick;
    drive(1'b0, 2'b00, 6'd0, '0, '0);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (md_done) begin
        lat = c;
        break;
      end
    end
  endtask

  int           lat;
  int           pulses;
  bit           got;
  logic [63:0]  prod;
  logic [W-1:0] ra, rb;

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_en = 1'b1;
    repeat (3) tick;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_md_done", {63'd0, md_done}, 64'd0);
    rst_n = 1'b1;
    tick;

    // alu_ctrl decode sweep (valid_in low so nothing is started)
    for (int f = 0; f < 64; f++) begin
      drive(1'b0, 2'b10, f[5:0], '0, '0);
      tick;
    end
    for (int op = 0; op < 4; op++) begin
      if (op != 2) begin
        for (int k = 0; k < 4; k++) begin
          drive(1'b0, op[1:0], 6'($urandom_range(0, 63)), '0, '0);
          tick;
        end
      end
    end
    drive(1'b0, 2'b10, 6'b100111, '0, '0); #1;
    chk("ctrl_nor", {60'd0, alu_ctrl}, 64'hC);
    drive(1'b0, 2'b10, 6'b000011, '0, '0); #1;
    chk("ctrl_sra", {60'd0, alu_ctrl}, 64'hA);
    drive(1'b0, 2'b01, 6'b100100, '0, '0); #1;
    chk("ctrl_beq", {60'd0, alu_ctrl}, 64'h6);
    tick;

    // MULTU 0xFFFFFFFF * 2
    run_md(F_MULTU, 32'hFFFF_FFFF, 32'd2, lat);
    chk("mul_latency", 64'(lat), 64'd32);
    chk("mul_hi", {32'd0, hi}, 64'h1);
    chk("mul_lo", {32'd0, lo}, 64'hFFFF_FFFE);
    tick;
    chk("md_done_one_cycle", {63'd0, md_done}, 64'd0);

    // MFLO issued 3 cycles after a MULTU start, ADD during busy
    ra = $urandom; rb = $urandom;
    prod = {32'd0, ra} * {32'd0, rb};
    drive(1'b1, 2'b10, F_MULTU, ra, rb); tick;
    drive(1'b0, 2'b00, 6'd0, '0, '0); tick;
    drive(1'b1, 2'b10, F_ADD, 32'd1, 32'd2); #1;
    chk("add_busy_stall", {63'd0, stall}, 64'd0);
    chk("add_busy_ctrl", {60'd0, alu_ctrl}, 64'h2);
    tick;
    drive(1'b1, 2'b10, F_MFLO, '0, '0);
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) begin
        got = 1'b1;
        break;
      end
      tick;
    end
    chk("mflo_released", {63'd0, got}, 64'd1);
    chk("mflo_in_done_cycle", {63'd0, md_done}, 64'd1);
    chk("mflo_data", {32'd0, hilo_rd}, {32'd0, prod[31:0]});
    tick;

    // MTHI / MTLO then divide (or divide no-op)
    drive(1'b1, 2'b10, F_MTHI, 32'hA5A5_0001, '0); tick;
    drive(1'b1, 2'b10, F_MTLO, 32'h5A5A_0002, '0); tick;
    drive(1'b1, 2'b10, F_MFHI, '0, '0); #1;
    chk("mthi_rd", {32'd0, hilo_rd}, 64'hA5A5_0001);
    tick;
`ifdef ALU_EXEC_DIV_EN
    run_md(F_DIVU, 32'd100, 32'd7, lat);
    chk("div_latency", 64'(lat), 64'd32);
    chk("div_lo", {32'd0, lo}, 64'd14);
    chk("div_hi", {32'd0, hi}, 64'd2);
    run_md(F_DIVU, 32'h1234, 32'd0, lat);
    chk("div0_latency", 64'(lat), 64'd32);
    chk("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    chk("div0_hi", {32'd0, hi}, 64'h1234);
`else
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 2'b10, F_DIVU, 32'd100, 32'd7); #1;
      if (stall) pulses++;
      tick;
      if (md_done) pulses++;
    end
    chk("divu_noop_activity", 64'(pulses), 64'd0);
    chk("divu_noop_hi", {32'd0, hi}, 64'hA5A5_0001);
    chk("divu_noop_lo", {32'd0, lo}, 64'h5A5A_0002);
`endif

    // Reset in the middle of a MULTU
    drive(1'b1, 2'b10, F_MULTU, 32'd7, 32'd9); tick;
    drive(1'b0, 2'b00, 6'd0, '0, '0);
    repeat (10) tick;
    drive(1'b1, 2'b10, F_MFLO, '0, '0);
    rst_n = 1'b0; #1;
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    chk("abort_stall", {63'd0, stall}, 64'd0);
    tick; tick;
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 6'd0, '0, '0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (md_done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_md(F_MULTU, 32'd12345, 32'd678, lat);
    chk("post_rst_latency", 64'(lat), 64'd32);
    chk("post_rst_lo", {32'd0, lo}, 64'd8369910);
    chk("post_rst_hi", {32'd0, hi}, 64'd0);

    // Randomized traffic, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] f;
      logic [1:0] op;
      case ($urandom_range(0, 3))
        0, 1: begin
          case ($urandom_range(0, 5))
            0: f = F_MULTU;
            1: f = F_DIVU;
            2: f = F_MFHI;
            3: f = F_MFLO;
            4: f = F_MTHI;
            default: f = F_MTLO;
          endcase
        end
        2: f = F_ADD;
        default: f = 6'($urandom_range(0, 63));
      endcase
      op = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      drive(($urandom_range(0, 9) < 8), op, f, ra, rb);
      tick;
    end

    drive(1'b0, 2'b00, 6'd0, '0, '0);
    tick;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; the block SHALL support any even value from 8 to 64.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: valid_in  input  1  EX-stage instruction valid.
REQ-005 Port: alu_op  input  2  main-control ALU opcode class.
REQ-006 Port: funct  input  6  R-type function field.
REQ-007 Port: rs_val, rt_val  input  WIDTH  operands.
REQ-008 Port: alu_ctrl  output  4  ALU operation code, combinational.
REQ-009 Port: hilo_rd  output  WIDTH  HI or LO read data for MFHI/MFLO, combinational.
REQ-010 Port: hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-011 Port: stall  output  1  freeze upstream pipeline, combinational.
REQ-012 Port: md_done  output  1  one-cycle pulse when multiply/divide results land.

Function
REQ-013 Decode for alu_op: 00 SHALL give 0010; 01 SHALL give 0110; 11 SHALL give 0010.
REQ-014 Decode for alu_op 10 SHALL follow funct: 100000/100001->0010, 100010/100011->0110, 100100->0000, 100101->0001, 100110->0011, 100111->1100, 101010->0111, 101011->1011, 000000->1000, 000010->1001, 000011->1010; any other funct SHALL give 0010.
REQ-015 HI/LO ops (alu_op=10, valid_in=1): MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010, MTHI 010001, MTLO 010011.
REQ-016 FSM states SHALL be IDLE, MUL and DIV; the block SHALL leave IDLE only on an accepted MULTU or DIVU.
REQ-017 An op SHALL be accepted when in IDLE: MULTU/DIVU latch rs_val/rt_val and enter MUL/DIV at that edge; stall SHALL NOT assert for the starting op.
REQ-018 MULTU SHALL be unsigned shift-add: one bit per cycle, WIDTH cycles, 2*WIDTH-bit product, HI = upper half, LO = lower half.
REQ-019 DIVU SHALL be unsigned restoring division: one bit per cycle, WIDTH cycles, LO = quotient, HI = remainder.
REQ-020 Divisor zero SHALL still take WIDTH cycles and yield LO = all ones, HI = rs_val.
REQ-021 Iteration counter width SHALL be clog2(WIDTH)+1; on the edge completing iteration WIDTH, hi/lo SHALL update, the FSM SHALL return to IDLE, and md_done SHALL be 1 for exactly the following cycle.
REQ-022 hi/lo SHALL hold during MUL/DIV; intermediate state SHALL stay internal.
REQ-023 stall SHALL be 1 whenever state != IDLE and valid_in=1 with any REQ-015 op; otherwise stall SHALL be 0 (non-HI/LO ops proceed under a busy unit).
REQ-024 MTHI/MTLO in IDLE SHALL write rs_val to hi/lo at the next edge.
REQ-025 hilo_rd SHALL equal hi for MFHI, lo for MFLO, and 0 otherwise; a stalled MFHI/MFLO SHALL see updated hi/lo in the md_done cycle, with stall=0 in that cycle.
REQ-026 A new MULTU/DIVU SHALL be accepted in the md_done cycle (back-to-back).
REQ-027 valid_in=0 SHALL suppress all state changes except in-flight iteration.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, hi=0, lo=0, md_done=0, counter=0, and all internal operand/accumulator registers to 0.
REQ-029 Reset during MUL/DIV SHALL abort the operation with no md_done pulse; stall SHALL go to 0 as a consequence of IDLE.

Configuration
REQ-030 Macro ALU_EXEC_DIV_EN: when defined, DIVU behaves per REQ-019/020.
REQ-031 When ALU_EXEC_DIV_EN is not defined: the DIV state and divider logic SHALL be absent; DIVU SHALL be a no-op (alu_ctrl 0010, no busy, hi/lo unchanged, no md_done).

Verification (WIDTH=32)
REQ-032 Test: MULTU rs=0xFFFFFFFF, rt=2 -> after 32 cycles hi=0x00000001, lo=0xFFFFFFFE; md_done high for one cycle.
REQ-033 Test: DIVU rs=100, rt=7 -> lo=14, hi=2; DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234.
REQ-034 Test: MFLO issued 3 cycles after MULTU start -> stall=1 until the md_done cycle, then hilo_rd = new lo; ADD issued during busy -> stall=0, alu_ctrl=0010.
REQ-035 Test: rst_n pulled low at cycle 10 of MULTU -> hi=lo=0 immediately, no md_done, next MULTU completes correctly.
REQ-036 Test: sweep all funct codes with alu_op=10, plus alu_op 00/01/11 -> alu_ctrl matches REQ-013/014.
REQ-037 Test: build without ALU_EXEC_DIV_EN, issue DIVU -> stall never asserts, hi/lo unchanged, md_done stays 0.
